// File: rtl/nn_node_mac.sv
// nn_node_mac: streaming fixed-point neuron node.
//
// Accepts one (in_data, in_weight) beat per cycle over a valid/ready handshake.
// Signed products accumulate into an overflow-free accumulator seeded with
// the bias aligned to the product Q format. After N_INPUTS beats the sum is
// rescaled, saturated to DATA_W bits and, optionally, passed through ReLU.
//
// Optional feature macro: NN_NODE_RELU_EN
//   defined   -> negative results clamp to 0 (hidden-layer node)
//   undefined -> signed saturated result passes through (output-layer node)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin an evaluation (honoured only when idle)
//   bias       node bias, sampled on the accepted start cycle
//   in_valid   in_data/in_weight valid
//   in_ready   node accepts a beat this cycle
//   in_data    activation from previous layer
//   in_weight  weight paired with in_data
//   out_valid  out_data holds a finished result
//   out_ready  consumer takes the result
//   out_data   node result
//   busy       high whenever the node is not idle
module nn_node_mac #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAC_BITS = 16,
  parameter int unsigned N_INPUTS  = 784
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  // Wide enough for N_INPUTS worst-case products plus the aligned bias.
  localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(N_INPUTS) + 1;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(N_INPUTS - 1);

  localparam logic signed [ACC_W-1:0] SatMax =
      {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin =
      {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StFinish,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [DATA_W-1:0]         out_q, out_d;

  logic signed [DATA_W-1:0]  data_s, weight_s, bias_s;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   bias_aligned;
  logic signed [ACC_W-1:0]   res;
  logic signed [DATA_W-1:0]  res_sat;
  logic        [DATA_W-1:0]  res_act;

  always_comb begin
    data_s       = signed'(in_data);
    weight_s     = signed'(in_weight);
    bias_s       = signed'(bias);
    prod         = PROD_W'(data_s) * PROD_W'(weight_s);
    // Bias is in DATA_W Q format; products carry 2*FRAC_BITS fraction bits.
    bias_aligned = ACC_W'(bias_s) <<< FRAC_BITS;
  end

  // Rescale (floor), saturate, activate.
  always_comb begin
    res = acc_q >>> FRAC_BITS;
    if (res > SatMax) begin
      res_sat = SatMax[DATA_W-1:0];
    end else if (res < SatMin) begin
      res_sat = SatMin[DATA_W-1:0];
    end else begin
      res_sat = res[DATA_W-1:0];
    end
`ifdef NN_NODE_RELU_EN
    res_act = res_sat[DATA_W-1] ? '0 : res_sat;
`else
    res_act = res_sat;
`endif
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = bias_aligned;
          count_d = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (in_valid) begin
          acc_d   = acc_q + ACC_W'(prod);
          count_d = count_q + CNT_W'(1);
          if (count_q == LastBeat) begin
            state_d = StFinish;
          end
        end
      end
      StFinish: begin
        out_d   = res_act;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_q;

endmodule

// File: tb/tb_nn_node_mac.sv
module tb_nn_node_mac;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] bias;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] in_weight;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  int n_vec;
  int n_err;

  nn_node_mac #(
    .DATA_W   (16),
    .FRAC_BITS(8),
    .N_INPUTS (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bias     (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_weight(in_weight),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0]       bias;
    logic [3:0][15:0]  data;
    logic [3:0][15:0]  weight;
    logic [15:0]       exp;
  } vec_t;

  vec_t vecs[8];

  // in_valid pattern 1,0,0,1,1,0,1 (bit 0 first)
  logic [6:0] gap_pat;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full evaluation starting from an IDLE cycle (called at #1 after an edge).
  // gaps: toggle in_valid; hold: cycles out_ready stays low in DONE;
  // inj: pulse start during ACCUM and DONE (must be ignored).
  task automatic run_eval(input vec_t v, input bit gaps, input int hold, input bit inj,
                          input string tag);
    int beat;
    int cyc;
    bit taken;
    chk1({tag, ".idle_busy"}, busy, 1'b0);
    bias      = v.bias;
    start     = 1'b1;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    bias  = 16'h7FFF;
    chk1({tag, ".in_ready_after_start"}, in_ready, 1'b1);
    chk1({tag, ".busy_accum"}, busy, 1'b1);
    beat = 0;
    cyc  = 0;
    while (beat < 4 && cyc < 40) begin
      in_valid  = gaps ? gap_pat[cyc % 7] : 1'b1;
      in_data   = v.data[beat];
      in_weight = v.weight[beat];
      start     = inj && (cyc == 1);
      taken     = in_valid && in_ready;
      tick();
      if (taken) beat++;
      cyc++;
    end
    start = 1'b0;
    chk16({tag, ".beats"}, 16'(beat), 16'd4);
    if (gaps) chk16({tag, ".beat_cycles"}, 16'(cyc), 16'd7);
    // FINISH: further beats must be refused.
    in_valid  = 1'b1;
    in_data   = 16'h7FFF;
    in_weight = 16'h7FFF;
    chk1({tag, ".finish_in_ready"}, in_ready, 1'b0);
    chk1({tag, ".finish_out_valid"}, out_valid, 1'b0);
    out_ready = (hold == 0);
    tick();
    chk1({tag, ".out_valid"}, out_valid, 1'b1);
    chk16({tag, ".out_data"}, out_data, v.exp);
    chk1({tag, ".busy_done"}, busy, 1'b1);
    for (int i = 0; i < hold; i++) begin
      start = inj;
      tick();
      chk1({tag, ".hold_valid"}, out_valid, 1'b1);
      chk16({tag, ".hold_data"}, out_data, v.exp);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1({tag, ".after_busy"}, busy, 1'b0);
    chk1({tag, ".after_valid"}, out_valid, 1'b0);
    chk1({tag, ".after_in_ready"}, in_ready, 1'b0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    gap_pat   = 7'b1011001;
    rst       = 1'b1;
    start     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
    out_ready = 1'b0;

    // Basic MAC: 0.5 + 4*1.0 = 4.5
    vecs[0] = '{bias: 16'h0080, data: {4{16'h0100}}, weight: {4{16'h0100}}, exp: 16'h0480};
`ifdef NN_NODE_RELU_EN
    vecs[1] = '{bias: 16'h0000, data: {4{16'h0100}}, weight: {4{16'hFF00}}, exp: 16'h0000};
    vecs[3] = '{bias: 16'h8000, data: {4{16'h7FFF}}, weight: {4{16'h8000}}, exp: 16'h0000};
    vecs[5] = '{bias: 16'h0000, data: {16'h0, 16'h0, 16'h0, 16'h0001},
                weight: {16'h0, 16'h0, 16'h0, 16'hFFFF}, exp: 16'h0000};
`else
    // Negative sum: -4.0
    vecs[1] = '{bias: 16'h0000, data: {4{16'h0100}}, weight: {4{16'hFF00}}, exp: 16'hFC00};
    // Negative saturation
    vecs[3] = '{bias: 16'h8000, data: {4{16'h7FFF}}, weight: {4{16'h8000}}, exp: 16'h8000};
    // Tiny negative product floors to -1 LSB
    vecs[5] = '{bias: 16'h0000, data: {16'h0, 16'h0, 16'h0, 16'h0001},
                weight: {16'h0, 16'h0, 16'h0, 16'hFFFF}, exp: 16'hFFFF};
`endif
    // Positive saturation
    vecs[2] = '{bias: 16'h7FFF, data: {4{16'h7FFF}}, weight: {4{16'h7FFF}}, exp: 16'h7FFF};
    // Mixed: -0.5 + 2.0 + 2.0 - 1.0 + 0.5 = 3.0
    vecs[4] = '{bias: 16'hFF80, data: {16'h0080, 16'hFF00, 16'h0200, 16'h0100},
                weight: {16'h0100, 16'h0100, 16'h0100, 16'h0200}, exp: 16'h0300};
    // Fractional products: 4 * 0x80 = 0x200 -> 2 LSB after rescale
    vecs[6] = '{bias: 16'h0000, data: {4{16'h0001}}, weight: {4{16'h0080}}, exp: 16'h0002};
    // One LSB above max saturates
    vecs[7] = '{bias: 16'h7FFF, data: {16'h0, 16'h0, 16'h0, 16'h0001},
                weight: {16'h0, 16'h0, 16'h0, 16'h0100}, exp: 16'h7FFF};

    // Reset state
    #2;
    chk1("rst.in_ready", in_ready, 1'b0);
    chk1("rst.out_valid", out_valid, 1'b0);
    chk1("rst.busy", busy, 1'b0);
    chk16("rst.out_data", out_data, 16'h0000);
    tick();
    rst = 1'b0;
    tick();

    // start honoured only with in IDLE; idle with no start stays idle
    chk1("idle.busy", busy, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_eval(vecs[i], 1'b0, 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Backpressure on both sides
    run_eval(vecs[0], 1'b1, 5, 1'b0, "bp");

    // Stray start pulses in ACCUM and DONE
    run_eval(vecs[0], 1'b0, 2, 1'b1, "ign_start");

    // Reset mid-accumulation discards the partial sum
    bias  = 16'h0080;
    start = 1'b1;
    tick();
    start     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0100;
    in_weight = 16'h0100;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk1("abort.in_ready", in_ready, 1'b0);
    chk1("abort.out_valid", out_valid, 1'b0);
    chk1("abort.busy", busy, 1'b0);
    chk16("abort.out_data", out_data, 16'h0000);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_eval(vecs[0], 1'b0, 0, 1'b0, "post_abort");

    // Back-to-back: second start lands in the single IDLE cycle
    run_eval(vecs[4], 1'b0, 0, 1'b0, "b2b_a");
    run_eval(vecs[0], 1'b0, 0, 1'b0, "b2b_b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule

// File: doc/nn_node_mac.md
# nn_node_mac

Parametrised, streaming fixed-point neuron node: accepts one (input, weight) pair per cycle over a valid/ready handshake, accumulates signed products into an overflow-free accumulator seeded with the bias, then rescales, saturates and optionally applies ReLU. It is the generic building block for every dense-layer node of the digit-detection network. Instantiate it once per node, with N_INPUTS set to the fan-in (784 for layer 0). A layer controller streams pixels and weights into it.

## Interface
- DATA_W, 32: width of input, weight, bias and result (signed two's complement, Q format).
- FRAC_BITS, 16: fractional bits of the Q format shared by all DATA_W operands.
- N_INPUTS, 784: number of (input, weight) beats per evaluation; must be >= 1.
- Derived, not overridable: ACC_W = 2*DATA_W + $clog2(N_INPUTS) + 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin an evaluation; honoured only in IDLE.
- bias  in  DATA_W  node bias; sampled on the accepted start cycle.
- in_valid  in  1  in_data/in_weight valid.
- in_ready  out  1  node accepts a beat this cycle.
- in_data  in  DATA_W  activation from previous layer.
- in_weight  in  DATA_W  weight paired with in_data.
- out_valid  out  1  out_data holds a finished result.
- out_ready  in  1  consumer takes the result.
- out_data  out  DATA_W  node result.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, ACCUM, FINISH, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1: acc <= sign-extended bias << FRAC_BITS, count <= 0, go to ACCUM.
- ACCUM:
  - in_ready=1.
  - Each cycle with in_valid && in_ready: acc <= acc + signed(in_data)*signed(in_weight) (full 2*DATA_W product, sign-extended), count <= count+1.
  - The beat accepted at count == N_INPUTS-1 moves the block to FINISH.
  - Cycles with in_valid=0 change nothing.
- FINISH (one cycle):
  - in_ready=0.
  - res = acc >>> FRAC_BITS (arithmetic, truncates toward -inf).
  - Saturate res to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Apply activation (see Configuration).
  - Register the result into out_data and go to DONE.
- DONE:
  - out_valid=1; out_data is stable until the handshake.
  - out_valid && out_ready: go to IDLE.
- start outside IDLE is ignored; it is not queued.
- The accumulator never overflows for any input values, because ACC_W covers N_INPUTS worst-case products plus the aligned bias.

## Timing
- Reset values: state=IDLE, acc=0, count=0, out_data=0, out_valid=0, in_ready=0, busy=0.
- rst asserted in any state aborts the evaluation immediately (asynchronous). The partial sum is discarded.
- start accepted at cycle t: in_ready=1 from cycle t+1.
- Minimum evaluation is N_INPUTS beat cycles.
- Last beat accepted at cycle t: out_valid=1 at cycle t+2.
- out_ready may already be high when out_valid rises; the handshake completes in that cycle and the block is IDLE the next cycle.
- Earliest next start is the first IDLE cycle, so back-to-back evaluations have one dead cycle after the handshake.
- N_INPUTS=1: start, one beat, FINISH, DONE.

## Configuration
- NN_NODE_RELU_EN defined: negative saturated results are replaced by 0 in FINISH (hidden-layer node).
- NN_NODE_RELU_EN undefined: the saturated result passes through unchanged, signed (output-layer node feeding argmax).
- Nothing else differs; latency is identical in both builds.

## Test plan
All scenarios use DATA_W=16, FRAC_BITS=8, N_INPUTS=4 (1.0 = 0x0100).
- Basic MAC: bias=0x0080, four beats of data=0x0100, weight=0x0100, in_valid held high -> out_valid two cycles after the 4th beat, out_data=0x0480 (4.5).
- Negative sum: bias=0, data=0x0100, weights=0xFF00 (-1.0) -> out_data=0x0000 with NN_NODE_RELU_EN; 0xFC00 without it.
- Saturation: data=weight=0x7FFF, bias=0x7FFF -> out_data=0x7FFF. Data=0x7FFF, weight=0x8000, bias=0x8000 without ReLU -> out_data=0x8000.
- Backpressure: in_valid toggling 1,0,0,1,1,0,1 with the basic-MAC values, out_ready low for 5 cycles after out_valid -> same 0x0480. out_data and out_valid stable while out_ready is low. Exactly 4 beats are consumed.
- Control robustness: start pulsed during ACCUM and DONE -> ignored, result unchanged. rst pulsed after 2 beats -> all outputs at reset values. A fresh start with the basic-MAC stimulus then yields 0x0480.
- Back-to-back: two evaluations with out_ready tied high -> second start accepted in the first IDLE cycle after the handshake. busy drops for exactly that one cycle.
